// File: rtl/commit_collect_mpu_pkg.sv
// Shared types and sizing for the MPU commit path.
package commit_collect_mpu_pkg;

  localparam int NUM_TPU            = 16;
  localparam int NUM_ISSUE          = 8;
  localparam int WIDTH_NUM_ISSUE    = $clog2(NUM_ISSUE);
  localparam int CNT_W              = WIDTH_NUM_ISSUE + 1;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_ISSUE);

  typedef struct packed {
    logic               valid;
    logic [NUM_TPU-1:0] pending;
  } commit_entry_t;

endpackage

// File: rtl/commit_collect_mpu_watchdog.sv
// Head-of-queue watchdog: counts cycles the head entry waits and latches its pending mask on expiry.
module commit_watchdog_mpu
  import commit_collect_mpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               head_valid,
  input  logic               advance,
  input  logic [NUM_TPU-1:0] head_pending,
  output logic               timeout,
  output logic [NUM_TPU-1:0] timeout_mask
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      timeout      <= 1'b0;
      timeout_mask <= '0;
    end else begin
      if (advance || !head_valid) cnt_q <= '0;
      else if (cnt_q != LIMIT)    cnt_q <= cnt_q + 1'b1;
      // Only the first expiry is captured; later heads do not overwrite the mask.
      if (!timeout && head_valid && !advance && cnt_q == LIMIT_M1) begin
        timeout      <= 1'b1;
        timeout_mask <= head_pending;
      end
    end
  end

endmodule

// File: rtl/commit_collect_mpu.sv
// Commit collector: tracks issued threads against their TPU enable mask, emits in-order commit pulses.
// Optional head watchdog is built when COMMIT_TIMEOUT_EN is defined.
module commit_collect_mpu
  import commit_collect_mpu_pkg::*;
`ifdef COMMIT_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               I_Req_Issue,
  input  logic [WIDTH_NUM_ISSUE-1:0]         I_IssueNo,
  input  logic [NUM_TPU-1:0]                 I_En_Exe,
  input  logic [NUM_TPU-1:0]                 I_Done,
  input  logic [NUM_TPU*WIDTH_NUM_ISSUE-1:0] I_Done_No,
  output logic                               O_Req_Commit,
  output logic [WIDTH_NUM_ISSUE-1:0]         O_CommitNo,
  output logic                               O_Full,
  output logic                               O_Empty,
  output logic                               O_Err,
  output logic                               O_Timeout,
  output logic [NUM_TPU-1:0]                 O_Timeout_Mask
);

  commit_entry_t [NUM_ISSUE-1:0]     tbl_q, tbl_d;
  logic [NUM_ISSUE-1:0][NUM_TPU-1:0] done_hit;
  logic [WIDTH_NUM_ISSUE-1:0]        head_q, commit_no_q;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic commit_fire, issue_ok, issue_err, done_err, req_q, err_q;

  // Scatter per-TPU done pulses into an entry x TPU hit matrix.
  always_comb begin
    done_hit = '0;
    for (int i = 0; i < NUM_TPU; i++)
      if (I_Done[i]) done_hit[I_Done_No[i*WIDTH_NUM_ISSUE +: WIDTH_NUM_ISSUE]][i] = 1'b1;
  end

  assign commit_fire = tbl_q[head_q].valid && (tbl_q[head_q].pending == '0);
  // The head slot retiring this cycle may be reissued in the same cycle.
  assign issue_ok    = I_Req_Issue &&
                       (!tbl_q[I_IssueNo].valid || (commit_fire && I_IssueNo == head_q));
  assign issue_err   = I_Req_Issue && !issue_ok;

  always_comb begin
    tbl_d    = tbl_q;
    done_err = 1'b0;
    for (int e = 0; e < NUM_ISSUE; e++) begin
      if (issue_ok && I_IssueNo == WIDTH_NUM_ISSUE'(e)) begin
        done_err        |= |(done_hit[e] & ~I_En_Exe);
        tbl_d[e].valid   = 1'b1;
        tbl_d[e].pending = I_En_Exe & ~done_hit[e];
      end else begin
        if (tbl_q[e].valid) begin
          done_err        |= |(done_hit[e] & ~tbl_q[e].pending);
          tbl_d[e].pending = tbl_q[e].pending & ~done_hit[e];
        end else begin
          done_err |= |done_hit[e];
        end
        if (commit_fire && head_q == WIDTH_NUM_ISSUE'(e)) tbl_d[e].valid = 1'b0;
      end
    end
  end

  assign count_d = count_q + CNT_W'(issue_ok) - CNT_W'(commit_fire);

  always_ff @(posedge clock) begin
    if (reset) begin
      tbl_q       <= '0;
      head_q      <= '0;
      count_q     <= '0;
      req_q       <= 1'b0;
      commit_no_q <= '0;
      err_q       <= 1'b0;
    end else begin
      tbl_q   <= tbl_d;
      head_q  <= head_q + WIDTH_NUM_ISSUE'(commit_fire);
      count_q <= count_d;
      req_q   <= commit_fire;
      if (commit_fire) commit_no_q <= head_q;
      err_q   <= err_q | issue_err | done_err;
    end
  end

  assign O_Req_Commit = req_q;
  assign O_CommitNo   = commit_no_q;
  assign O_Full       = (count_q == CNT_FULL);
  assign O_Empty      = (count_q == '0);
  assign O_Err        = err_q;

`ifdef COMMIT_TIMEOUT_EN
  commit_watchdog_mpu #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock        (clock),
    .reset        (reset),
    .head_valid   (tbl_q[head_q].valid),
    .advance      (commit_fire),
    .head_pending (tbl_q[head_q].pending),
    .timeout      (O_Timeout),
    .timeout_mask (O_Timeout_Mask)
  );
`else
  assign O_Timeout      = 1'b0;
  assign O_Timeout_Mask = '0;
`endif

endmodule

// File: tb/tb_commit_collect_mpu.sv
// Bench for commit_collect_mpu: directed scenarios plus randomized legal traffic against a queue-level model.
module tb_commit_collect_mpu;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Req_Issue;
  logic [2:0]  I_IssueNo;
  logic [15:0] I_En_Exe;
  logic [15:0] I_Done;
  logic [47:0] I_Done_No;
  logic        O_Req_Commit;
  logic [2:0]  O_CommitNo;
  logic        O_Full, O_Empty, O_Err, O_Timeout;
  logic [15:0] O_Timeout_Mask;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit          m_valid[8];
  logic [15:0] m_pend[8];
  int          m_head, m_count, exp_no;
  bit          exp_req;

`ifdef COMMIT_TIMEOUT_EN
  commit_collect_mpu #(.TIMEOUT_CYCLES(16)) dut (
`else
  commit_collect_mpu dut (
`endif
    .clock(clock), .reset(reset), .I_Req_Issue(I_Req_Issue), .I_IssueNo(I_IssueNo),
    .I_En_Exe(I_En_Exe), .I_Done(I_Done), .I_Done_No(I_Done_No),
    .O_Req_Commit(O_Req_Commit), .O_CommitNo(O_CommitNo), .O_Full(O_Full), .O_Empty(O_Empty),
    .O_Err(O_Err), .O_Timeout(O_Timeout), .O_Timeout_Mask(O_Timeout_Mask));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    I_Req_Issue = 1'b0; I_IssueNo = '0; I_En_Exe = '0; I_Done = '0; I_Done_No = '0;
  endtask

  task automatic set_issue(input int no, input logic [15:0] mask);
    I_Req_Issue = 1'b1; I_IssueNo = 3'(no); I_En_Exe = mask;
  endtask

  task automatic set_done(input int tpu, input int no);
    I_Done[tpu] = 1'b1; I_Done_No[tpu*3 +: 3] = 3'(no);
  endtask

  task automatic do_reset();
    clear_in(); reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (O_Req_Commit !== 1'b0) $display("FAIL reset_req got %b exp 0", O_Req_Commit); else n_pass++;
    n_checks++; if (O_CommitNo !== 3'd0) $display("FAIL reset_no got %0d exp 0", O_CommitNo); else n_pass++;
    n_checks++; if (O_Full !== 1'b0) $display("FAIL reset_full got %b exp 0", O_Full); else n_pass++;
    n_checks++; if (O_Empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", O_Empty); else n_pass++;
    n_checks++; if (O_Err !== 1'b0) $display("FAIL reset_err got %b exp 0", O_Err); else n_pass++;
    n_checks++; if (O_Timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", O_Timeout); else n_pass++;
    n_checks++; if (O_Timeout_Mask !== 16'h0) $display("FAIL reset_tmask got %h exp 0", O_Timeout_Mask); else n_pass++;
  endtask

  task automatic test_basic_latency();
    do_reset();
    set_issue(0, 16'h0003); step(); clear_in();
    set_done(0, 0); step(); clear_in();
    step(); step();
    set_done(1, 0); step(); clear_in();
    n_checks++; if (O_Req_Commit !== 1'b0) $display("FAIL basic_early got %b exp 0", O_Req_Commit); else n_pass++;
    step();
    n_checks++; if (O_Req_Commit !== 1'b1) $display("FAIL basic_req got %b exp 1", O_Req_Commit); else n_pass++;
    n_checks++; if (O_CommitNo !== 3'd0) $display("FAIL basic_no got %0d exp 0", O_CommitNo); else n_pass++;
    step();
    n_checks++; if (O_Req_Commit !== 1'b0) $display("FAIL basic_pulse got %b exp 0", O_Req_Commit); else n_pass++;
    n_checks++; if (O_Empty !== 1'b1) $display("FAIL basic_empty got %b exp 1", O_Empty); else n_pass++;
  endtask

  task automatic test_in_order();
    bit any_req = 0;
    do_reset();
    set_issue(0, 16'h0001); step();
    set_issue(1, 16'h0002); step(); clear_in();
    set_done(1, 1); step(); clear_in();
    for (int k = 0; k < 9; k++) begin step(); if (O_Req_Commit) any_req = 1; end
    n_checks++; if (any_req !== 1'b0) $display("FAIL order_wait got %b exp 0", any_req); else n_pass++;
    set_done(0, 0); step(); clear_in();
    step();
    n_checks++; if ({O_Req_Commit, O_CommitNo} !== 4'b1_000) $display("FAIL order_first got %b/%0d exp 1/0", O_Req_Commit, O_CommitNo); else n_pass++;
    step();
    n_checks++; if ({O_Req_Commit, O_CommitNo} !== 4'b1_001) $display("FAIL order_second got %b/%0d exp 1/1", O_Req_Commit, O_CommitNo); else n_pass++;
    step();
    n_checks++; if (O_Req_Commit !== 1'b0) $display("FAIL order_end got %b exp 0", O_Req_Commit); else n_pass++;
  endtask

  task automatic test_full_wrap();
    int got[$];
    bit ok;
    do_reset();
    for (int k = 0; k < 8; k++) begin set_issue(k, 16'h0001); step(); end
    clear_in();
    n_checks++; if ({O_Full, O_Empty} !== 2'b10) $display("FAIL full_flags got %b%b exp 10", O_Full, O_Empty); else n_pass++;
    n_checks++; if (O_Err !== 1'b0) $display("FAIL full_noerr got %b exp 0", O_Err); else n_pass++;
    set_issue(0, 16'hFFFF); step(); clear_in();
    n_checks++; if (O_Err !== 1'b1) $display("FAIL full_err got %b exp 1", O_Err); else n_pass++;
    n_checks++; if (O_Full !== 1'b1) $display("FAIL full_hold got %b exp 1", O_Full); else n_pass++;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) set_done(0, k);
      step(); clear_in();
      if (O_Req_Commit) got.push_back(int'(O_CommitNo));
    end
    ok = (got.size() == 8);
    if (ok) for (int k = 0; k < 8; k++) if (got[k] != k) ok = 0;
    n_checks++; if (ok !== 1'b1) $display("FAIL wrap_order got %0d commits exp 8 in order 0..7", got.size()); else n_pass++;
    n_checks++; if ({O_Full, O_Empty} !== 2'b01) $display("FAIL wrap_empty got %b%b exp 01", O_Full, O_Empty); else n_pass++;
    set_issue(0, 16'h0000); step(); clear_in(); step();
    n_checks++; if ({O_Req_Commit, O_CommitNo} !== 4'b1_000) $display("FAIL wrap_head got %b/%0d exp 1/0", O_Req_Commit, O_CommitNo); else n_pass++;
    n_checks++; if (O_Err !== 1'b1) $display("FAIL err_sticky got %b exp 1", O_Err); else n_pass++;
  endtask

  task automatic test_same_cycle_done();
    do_reset();
    set_issue(0, 16'h0001); step();
    set_issue(1, 16'h0001); step(); clear_in();
    set_done(0, 0); step(); clear_in();
    set_done(0, 1); step(); clear_in();
    step(); step(); step();
    set_issue(2, 16'h0004); set_done(2, 2); step(); clear_in();
    n_checks++; if (O_Req_Commit !== 1'b0) $display("FAIL same_early got %b exp 0", O_Req_Commit); else n_pass++;
    step();
    n_checks++; if ({O_Req_Commit, O_CommitNo} !== 4'b1_010) $display("FAIL same_commit got %b/%0d exp 1/2", O_Req_Commit, O_CommitNo); else n_pass++;
    n_checks++; if (O_Err !== 1'b0) $display("FAIL same_noerr got %b exp 0", O_Err); else n_pass++;
    set_done(3, 5); step(); clear_in();
    n_checks++; if (O_Err !== 1'b1) $display("FAIL invalid_done_err got %b exp 1", O_Err); else n_pass++;
  endtask

  task automatic test_zero_mask_reset();
    bit any_req = 0;
    do_reset();
    set_issue(0, 16'h0000); step(); clear_in();
    n_checks++; if (O_Req_Commit !== 1'b0) $display("FAIL zero_early got %b exp 0", O_Req_Commit); else n_pass++;
    step();
    n_checks++; if ({O_Req_Commit, O_CommitNo} !== 4'b1_000) $display("FAIL zero_commit got %b/%0d exp 1/0", O_Req_Commit, O_CommitNo); else n_pass++;
    for (int k = 1; k < 4; k++) begin set_issue(k, 16'h0001); step(); end
    clear_in();
    n_checks++; if (O_Empty !== 1'b0) $display("FAIL mid_nonempty got %b exp 0", O_Empty); else n_pass++;
    reset = 1'b1; step();
    n_checks++; if ({O_Req_Commit, O_CommitNo, O_Full, O_Empty, O_Err} !== 7'b0_000_010)
      $display("FAIL mid_reset got %b exp 0000010", {O_Req_Commit, O_CommitNo, O_Full, O_Empty, O_Err}); else n_pass++;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin step(); if (O_Req_Commit) any_req = 1; end
    n_checks++; if (any_req !== 1'b0) $display("FAIL dropped_commit got %b exp 0", any_req); else n_pass++;
    n_checks++; if (O_Empty !== 1'b1) $display("FAIL post_reset_empty got %b exp 1", O_Empty); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    set_issue(0, 16'h0030); step(); clear_in();
    set_done(4, 0); step(); clear_in();
    for (int k = 0; k < 20; k++) step();
`ifdef COMMIT_TIMEOUT_EN
    n_checks++; if (O_Timeout !== 1'b1) $display("FAIL timeout_flag got %b exp 1", O_Timeout); else n_pass++;
    n_checks++; if (O_Timeout_Mask !== 16'h0020) $display("FAIL timeout_mask got %h exp 0020", O_Timeout_Mask); else n_pass++;
`else
    n_checks++; if (O_Timeout !== 1'b0) $display("FAIL timeout_flag got %b exp 0", O_Timeout); else n_pass++;
    n_checks++; if (O_Timeout_Mask !== 16'h0000) $display("FAIL timeout_mask got %h exp 0000", O_Timeout_Mask); else n_pass++;
`endif
    n_checks++; if (O_Req_Commit !== 1'b0) $display("FAIL timeout_nocommit got %b exp 0", O_Req_Commit); else n_pass++;
  endtask

  // Model advances one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit ready;
    int n;
    ready = m_valid[m_head] && (m_pend[m_head] == 16'h0);
    for (int i = 0; i < 16; i++)
      if (I_Done[i]) begin n = int'(I_Done_No[i*3 +: 3]); m_pend[n][i] = 1'b0; end
    exp_req = ready;
    if (ready) begin
      exp_no = m_head; m_valid[m_head] = 0; m_head = (m_head + 1) % 8; m_count--;
    end
    if (I_Req_Issue) begin
      n = int'(I_IssueNo); m_valid[n] = 1; m_pend[n] = I_En_Exe; m_count++;
    end
  endtask

  task automatic drive_random(input bit allow_issue);
    int e, start;
    clear_in();
    if (allow_issue && m_count < 8 && $urandom_range(0, 2) == 0) begin
      I_Req_Issue = 1'b1;
      I_IssueNo   = 3'((m_head + m_count) % 8);
      I_En_Exe    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom & $urandom);
    end
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        start = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++) begin
          e = (start + k) % 8;
          if (m_valid[e] && m_pend[e][i]) begin set_done(i, e); break; end
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 8; k++) begin m_valid[k] = 0; m_pend[k] = '0; end
    m_head = 0; m_count = 0; exp_no = 0; exp_req = 0;
    for (int c = 0; c < 700; c++) begin
      drive_random(c < 400);
      model_edge();
      step();
      n_checks++; if (O_Req_Commit !== exp_req) $display("FAIL rnd_req c=%0d got %b exp %b", c, O_Req_Commit, exp_req); else n_pass++;
      if (exp_req) begin
        n_checks++; if (O_CommitNo !== 3'(exp_no)) $display("FAIL rnd_no c=%0d got %0d exp %0d", c, O_CommitNo, exp_no); else n_pass++;
      end
      n_checks++; if ({O_Full, O_Empty} !== {m_count == 8, m_count == 0})
        $display("FAIL rnd_flags c=%0d got %b%b exp %b%b", c, O_Full, O_Empty, m_count == 8, m_count == 0); else n_pass++;
      n_checks++; if (O_Err !== 1'b0) $display("FAIL rnd_err c=%0d got %b exp 0", c, O_Err); else n_pass++;
    end
    clear_in();
    n_checks++; if (O_Empty !== 1'b1) $display("FAIL rnd_drained got %b exp 1", O_Empty); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    test_reset();
    test_basic_latency();
    test_in_order();
    test_full_wrap();
    test_same_cycle_done();
    test_zero_mask_reset();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
